// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix/vector operand loader.
// Loader states, default operand dimensions and index-width helper.
package matvec_pkg;

  localparam int MDATA = 4;
  localparam int NDATA = 4;
  localparam int NBITS = 8;

  typedef enum logic [1:0] {
    LOAD_M = 2'd0,
    LOAD_X = 2'd1,
    HOLD   = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = idx_w(MDATA);
  localparam int COL_W = idx_w(NDATA);

endpackage

// File: rtl/matvec_idx_counter.sv
// Mod-N index counter with increment, synchronous clear and a wrap pulse.
// wrap_o is combinational so a dependent counter can step on the same edge.
module matvec_idx_counter
  import matvec_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = inc_i && (cnt_q == W'(N - 1));
  assign cnt_o  = cnt_q;

  // next-count selection: clear, wrap to zero, or step
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mat_vec_operand_loader.sv
// Serial word stream -> held matrix M / vector X operand set for the mat-vec multiplier.
// Optional MATVEC_KEEP_MATRIX_EN adds keep_m to reload only X between sets.
module mat_vec_operand_loader
  import matvec_pkg::*;
#(
  parameter int Mdata = MDATA,
  parameter int Ndata = NDATA,
  parameter int Nbits = NBITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [Nbits-1:0]             s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [Mdata*Ndata*Nbits-1:0] M,
  output logic [Ndata*Nbits-1:0]       X,
  output logic                         m_valid,
  input  logic                         m_ready,
`ifdef MATVEC_KEEP_MATRIX_EN
  input  logic                         keep_m,
`endif
  output logic                         busy
);

  localparam int RW = idx_w(Mdata);
  localparam int CW = idx_w(Ndata);

  state_e                         state_q;
  logic                           m_valid_q;
  logic                           s_ready_q;
  logic                           busy_q;
  logic [Mdata*Ndata*Nbits-1:0]   m_q;
  logic [Ndata*Nbits-1:0]         x_q;

  logic [RW-1:0]                  row_s;
  logic [CW-1:0]                  col_s;
  logic                           col_wrap_s;
  logic                           row_wrap_s;
  logic                           xfer_s;
  logic                           xfer_m_s;
  logic                           xfer_x_s;
  logic                           hold_exit_s;
  state_e                         next_load_s;
  logic [Mdata*Ndata-1:0]         we_m_s;
  logic [Ndata-1:0]               we_x_s;

  assign xfer_s      = s_valid && s_ready_q;
  assign xfer_m_s    = xfer_s && (state_q == LOAD_M);
  assign xfer_x_s    = xfer_s && (state_q == LOAD_X);
  assign hold_exit_s = (state_q == HOLD) && m_ready;

  matvec_idx_counter #(.N(Ndata), .W(CW)) u_col (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (hold_exit_s),
    .inc_i  (xfer_s),
    .cnt_o  (col_s),
    .wrap_o (col_wrap_s)
  );

  matvec_idx_counter #(.N(Mdata), .W(RW)) u_row (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (hold_exit_s),
    .inc_i  (xfer_m_s && col_wrap_s),
    .cnt_o  (row_s),
    .wrap_o (row_wrap_s)
  );

  // load phase entered when the consumer releases the held set
  always_comb begin
`ifdef MATVEC_KEEP_MATRIX_EN
    next_load_s = keep_m ? LOAD_X : LOAD_M;
`else
    next_load_s = LOAD_M;
`endif
  end

  // one-hot element write enables from the current row/col index
  always_comb begin
    we_m_s = '0;
    we_x_s = '0;
    for (int r = 0; r < Mdata; r++) begin
      for (int c = 0; c < Ndata; c++) begin
        we_m_s[r*Ndata+c] = xfer_m_s && (row_s == RW'(r)) && (col_s == CW'(c));
      end
    end
    for (int c = 0; c < Ndata; c++) begin
      we_x_s[c] = xfer_x_s && (col_s == CW'(c));
    end
  end

  // loader FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD_M;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        LOAD_M: begin
          if (xfer_m_s && row_wrap_s) begin
            state_q <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (xfer_x_s && col_wrap_s) begin
            state_q   <= HOLD;
            m_valid_q <= 1'b1;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        HOLD: begin
          if (m_ready) begin
            state_q   <= next_load_s;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= LOAD_M;
          m_valid_q <= 1'b0;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // operand storage; locations are only overwritten, never cleared between sets
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      x_q <= '0;
    end else begin
      for (int e = 0; e < Mdata*Ndata; e++) begin
        if (we_m_s[e]) begin
          m_q[e*Nbits +: Nbits] <= s_data;
        end
      end
      for (int c = 0; c < Ndata; c++) begin
        if (we_x_s[c]) begin
          x_q[c*Nbits +: Nbits] <= s_data;
        end
      end
    end
  end

  assign M       = m_q;
  assign X       = x_q;
  assign m_valid = m_valid_q;
  assign s_ready = s_ready_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mat_vec_operand_loader.sv
// Directed self-checking bench for mat_vec_operand_loader (4x4, 8-bit defaults).
module tb_mat_vec_operand_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] M;
  logic [31:0]  X;
  logic         m_valid;
  logic         m_ready;
  logic         keep_m;
  logic         busy;

  int passes = 0;
  int total  = 0;
  int cyc_a;
  int cyc_b;

  logic [7:0]   words [20];
  logic [7:0]   set_a [20];

  localparam logic [127:0] M_A = {32'h01030502, 32'h04050000, 32'h04030201, 32'h05060701};
  localparam logic [31:0]  X_A = 32'h01020101;

  mat_vec_operand_loader dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .M       (M),
    .X       (X),
    .m_valid (m_valid),
    .m_ready (m_ready),
`ifdef MATVEC_KEEP_MATRIX_EN
    .keep_m  (keep_m),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // stream words[first .. first+n-1]; gaps inserts one idle cycle after each offered word
  task automatic send(input int first, input int n, input bit gaps, output int cyc);
    int  idx;
    logic rdy;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 300) begin
      s_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      s_data  = words[first+idx];
      if (!s_valid) chk("s_ready_in_gap", {127'd0, s_ready}, 128'd1);
      rdy = s_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (s_valid && rdy) idx++;
    end
    s_valid = 1'b0;
    if (idx < n) chk("stream_timeout", 128'(idx), 128'(n));
  endtask

  task automatic release_set();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  initial begin
    set_a = '{8'd1, 8'd7, 8'd6, 8'd5, 8'd1, 8'd2, 8'd3, 8'd4,
              8'd0, 8'd0, 8'd5, 8'd4, 8'd2, 8'd5, 8'd3, 8'd1,
              8'd1, 8'd1, 8'd2, 8'd1};
    rst = 1'b1; s_data = 8'd0; s_valid = 1'b0; m_ready = 1'b0; keep_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", {127'd0, m_valid}, 128'd0);
    chk("reset_s_ready", {127'd0, s_ready}, 128'd1);
    chk("reset_busy",    {127'd0, busy},    128'd1);
    chk("reset_M",       M,                 128'd0);
    chk("reset_X",       {96'd0, X},        128'd0);
    rst = 1'b0;

    // 1: back-to-back stream, m_valid right after the 20th word
    words = set_a;
    send(0, 19, 1'b0, cyc_a);
    chk("t1_no_valid_early", {127'd0, m_valid}, 128'd0);
    send(19, 1, 1'b0, cyc_b);
    chk("t1_latency",  128'(cyc_a + cyc_b), 128'd20);
    chk("t1_m_valid",  {127'd0, m_valid}, 128'd1);
    chk("t1_busy",     {127'd0, busy},    128'd0);
    chk("t1_s_ready",  {127'd0, s_ready}, 128'd0);
    chk("t1_M",        M,                 M_A);
    chk("t1_X",        {96'd0, X},        {96'd0, X_A});

    // 3: HOLD ignores incoming words
    s_valid = 1'b1; s_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t3_s_ready", {127'd0, s_ready}, 128'd0);
      chk("t3_m_valid", {127'd0, m_valid}, 128'd1);
    end
    s_valid = 1'b0;
    chk("t3_M", M,          M_A);
    chk("t3_X", {96'd0, X}, {96'd0, X_A});

    // 5: one-cycle release then overwrite with 8'h11
    release_set();
    chk("t5_m_valid", {127'd0, m_valid}, 128'd0);
    chk("t5_s_ready", {127'd0, s_ready}, 128'd1);
    chk("t5_busy",    {127'd0, busy},    128'd1);
    for (int i = 0; i < 20; i++) words[i] = 8'h11;
    send(0, 20, 1'b0, cyc_a);
    chk("t5_latency", 128'(cyc_a), 128'd20);
    chk("t5_M", M,          {16{8'h11}});
    chk("t5_X", {96'd0, X}, {96'd0, {4{8'h11}}});

    // 2: alternating valid, counters pause in gaps
    release_set();
    words = set_a;
    send(0, 20, 1'b1, cyc_a);
    chk("t2_latency", 128'(cyc_a), 128'd39);
    chk("t2_m_valid", {127'd0, m_valid}, 128'd1);
    chk("t2_M", M,          M_A);
    chk("t2_X", {96'd0, X}, {96'd0, X_A});

    // 4: m_ready while loading is ignored; reset mid-load discards everything
    release_set();
    m_ready = 1'b1;
    send(0, 10, 1'b0, cyc_a);
    chk("t4_loading_s_ready", {127'd0, s_ready}, 128'd1);
    chk("t4_loading_m_valid", {127'd0, m_valid}, 128'd0);
    m_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t4_rst_M",       M,                 128'd0);
    chk("t4_rst_X",       {96'd0, X},        128'd0);
    chk("t4_rst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("t4_rst_s_ready", {127'd0, s_ready}, 128'd1);
    send(0, 20, 1'b0, cyc_a);
    chk("t4_latency", 128'(cyc_a), 128'd20);
    chk("t4_M", M,          M_A);
    chk("t4_X", {96'd0, X}, {96'd0, X_A});

`ifdef MATVEC_KEEP_MATRIX_EN
    // 6: keep matrix, reload only the vector
    keep_m = 1'b1;
    release_set();
    keep_m = 1'b0;
    chk("t6_s_ready", {127'd0, s_ready}, 128'd1);
    for (int i = 0; i < 4; i++) words[i] = 8'h03;
    send(0, 4, 1'b0, cyc_a);
    chk("t6_latency", 128'(cyc_a), 128'd4);
    chk("t6_m_valid", {127'd0, m_valid}, 128'd1);
    chk("t6_M", M,          M_A);
    chk("t6_X", {96'd0, X}, {96'd0, 32'h03030303});
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
